// File: rtl/mult_result_sequencer_pkg.sv
// Shared types and default widths for the multiplier result sequencer.
package mult_result_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    localparam int unsigned DefDataW   = 16;
    localparam int unsigned DefStepW   = 8;
    localparam int unsigned DefTimeout = 255;

endpackage

// File: rtl/mult_result_sequencer_sync_fifo.sv
// Synchronous FIFO with occupancy count; head is presented combinationally and reads 0 when empty.
module mult_result_sequencer_sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CntW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt_q;
    assign rdata   = empty ? '0 : mem[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mult_result_sequencer.sv
// Issues multiplier starts, queues {product, step} results and optionally accumulates them.
// Optional accumulator enabled by defining MULT_SEQ_ACCUM_EN.
module mult_result_sequencer
    import mult_result_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned STEP_W  = DefStepW,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic                    start,
    input  logic                    done,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [STEP_W-1:0]       step_in,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic [STEP_W-1:0]       m_step,
    output logic [$clog2(DEPTH):0]  count,
    output logic [ACC_W-1:0]        acc,
    output logic                    acc_ovf,
    input  logic                    acc_clr,
    output logic                    err_timeout
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
    localparam int unsigned EntW = DATA_W + STEP_W;

    state_e          state_q, state_d;
    logic [WdW-1:0]  wd_q, wd_d;
    logic            err_q, err_d;
    logic            push, pop, empty, unused_full;
    logic [EntW-1:0] head;

    assign pop         = m_valid && m_ready;
    assign m_valid     = !empty;
    assign m_data      = head[EntW-1:STEP_W];
    assign m_step      = head[STEP_W-1:0];
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        err_d   = err_q;
        push    = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            // A slot freed by this cycle's pop may be reserved immediately.
            StIdle: begin
                if (run && !err_q && ((count - CntW'(pop)) < CntW'(DEPTH))) state_d = StIssue;
            end
            StIssue: begin
                start   = 1'b1;
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                if (done) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    mult_result_sequencer_sync_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({data_in, step_in}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (unused_full),
        .empty (empty)
    );

`ifdef MULT_SEQ_ACCUM_EN
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(data_in);

    // A clear coinciding with a push restarts the sum from the new product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (push) begin
            if (acc_clr) begin
                acc_q <= ACC_W'(data_in);
                ovf_q <= 1'b0;
            end else begin
                acc_q <= acc_sum[ACC_W-1:0];
                ovf_q <= ovf_q | acc_sum[ACC_W];
            end
        end else if (acc_clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end
    end

    assign acc     = acc_q;
    assign acc_ovf = ovf_q;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
    assign acc            = '0;
    assign acc_ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_mult_result_sequencer.sv
// Directed bench for mult_result_sequencer with a behavioural multiplier model.
module tb_mult_result_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        start;
    logic        done = 1'b0;
    logic [15:0] data_in = '0;
    logic [7:0]  step_in = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic [7:0]  m_step;
    logic [2:0]  count;
    logic [23:0] acc;
    logic        acc_ovf;
    logic        acc_clr = 1'b0;
    logic        err_timeout;

    mult_result_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .start       (start),
        .done        (done),
        .data_in     (data_in),
        .step_in     (step_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_step      (m_step),
        .count       (count),
        .acc         (acc),
        .acc_ovf     (acc_ovf),
        .acc_clr     (acc_clr),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Multiplier model: done pulses mdl_lat cycles after the start cycle.
    logic [15:0] mdl_data = '0;
    logic [7:0]  mdl_step = '0;
    int          mdl_lat = 1;
    logic        mdl_inc = 1'b0;
    logic        mdl_never = 1'b0;
    int          n_starts = 0;
    int          n_dones = 0;
    int          cnt = 0;

    always @(negedge clk) begin
        done = 1'b0;
        if (start) begin
            n_starts = n_starts + 1;
            if (!mdl_never) cnt = mdl_lat;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                done    = 1'b1;
                data_in = mdl_inc ? mdl_data + 16'(n_dones) : mdl_data;
                step_in = mdl_step;
                n_dones = n_dones + 1;
            end
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_count(input int target, input int bound, input string name);
        int k = 0;
        while (32'(count) != target && k < bound) begin
            tick();
            k++;
        end
        check(name, 32'(count), 32'(target));
    endtask

    typedef struct {
        logic [15:0] data;
        logic [7:0]  step;
        int          lat;
        logic [15:0] exp_data;
        logic [7:0]  exp_step;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int s0, d0, k;
        longint exp_sum;

        vecs[0] = '{16'h0C35, 8'd8,  17, 16'h0C35, 8'd8};
        vecs[1] = '{16'hFFFF, 8'd16, 3,  16'hFFFF, 8'd16};
        vecs[2] = '{16'h0000, 8'd0,  1,  16'h0000, 8'd0};
        vecs[3] = '{16'h8001, 8'd1,  5,  16'h8001, 8'd1};

        do_reset();
        check("rst_start", 32'(start), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_step", 32'(m_step), 0);
        check("rst_count", 32'(count), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_ovf", 32'(acc_ovf), 0);
        check("rst_err", 32'(err_timeout), 0);

        // Single products, one at a time
        for (int i = 0; i < 4; i++) begin
            mdl_data = vecs[i].data;
            mdl_step = vecs[i].step;
            mdl_lat  = vecs[i].lat;
            s0       = n_starts;
            pulse_run();
            check("start_next_cycle", 32'(start), 1);
            wait_count(1, vecs[i].lat + 6, "vec_count");
            check("vec_valid", 32'(m_valid), 1);
            check("vec_data", 32'(m_data), 32'(vecs[i].exp_data));
            check("vec_step", 32'(m_step), 32'(vecs[i].exp_step));
            check("vec_one_start", 32'(n_starts - s0), 1);
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            check("vec_popped", 32'(count), 0);
        end

`ifdef MULT_SEQ_ACCUM_EN
`else
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("noacc_acc", 32'(acc), 0);
        check("noacc_ovf", 32'(acc_ovf), 0);
`endif

        // Backpressure: FIFO fills at DEPTH, then one pop admits one more start
        mdl_data = 16'h1000;
        mdl_step = 8'd4;
        mdl_lat  = 3;
        mdl_inc  = 1'b1;
        s0       = n_starts;
        d0       = n_dones;
        run      = 1'b1;
        repeat (60) tick();
        check("full_starts", 32'(n_starts - s0), 4);
        check("full_count", 32'(count), 4);
        check("full_idle", 32'(start), 0);
        check("full_head", 32'(m_data), 32'(16'h1000 + 16'(d0)));
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("refill_start", 32'(start), 1);
        run = 1'b0;
        wait_count(4, 20, "refill_count");
        check("refill_starts", 32'(n_starts - s0), 5);
        m_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            check("drain_order", 32'(m_data), 32'(16'h1000 + 16'(d0 + j)));
            tick();
        end
        m_ready = 1'b0;
        check("drain_empty", 32'(count), 0);
        mdl_inc = 1'b0;

        // Simultaneous push and pop at count 2
        mdl_lat = 2;
        mdl_data = 16'h00AA; mdl_step = 8'd1; pulse_run(); wait_count(1, 10, "pp_a");
        mdl_data = 16'h00BB; mdl_step = 8'd2; pulse_run(); wait_count(2, 10, "pp_b");
        mdl_data = 16'h00CC; mdl_step = 8'd3; mdl_lat = 4; pulse_run();
        k = 0;
        while (done !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        check("pp_done_seen", 32'(done), 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("pp_count", 32'(count), 2);
        check("pp_head_data", 32'(m_data), 32'h00BB);
        check("pp_head_step", 32'(m_step), 2);
        m_ready = 1'b1;
        tick();
        check("pp_tail_data", 32'(m_data), 32'h00CC);
        tick();
        m_ready = 1'b0;
        check("pp_empty", 32'(count), 0);

        // Watchdog: done never arrives
        do_reset();
        mdl_never = 1'b1;
        s0  = n_starts;
        run = 1'b1;
        k   = 0;
        while (start !== 1'b1 && k < 5) begin
            tick();
            k++;
        end
        check("to_start", 32'(start), 1);
        repeat (255) tick();
        check("to_err_pending", 32'(err_timeout), 0);
        tick();
        check("to_err_set", 32'(err_timeout), 1);
        repeat (20) tick();
        check("to_no_restart", 32'(n_starts - s0), 1);
        check("to_count", 32'(count), 0);
        run = 1'b0;
        mdl_never = 1'b0;
        do_reset();
        check("to_err_cleared", 32'(err_timeout), 0);

        // Asynchronous reset mid-WAIT with two entries queued
        mdl_lat = 2;
        mdl_data = 16'h0011; mdl_step = 8'd5; pulse_run(); wait_count(1, 10, "ar_a");
        mdl_data = 16'h0022; mdl_step = 8'd6; pulse_run(); wait_count(2, 10, "ar_b");
        mdl_lat = 20;
        pulse_run();
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 32'(m_valid), 0);
        check("ar_count", 32'(count), 0);
        check("ar_data", 32'(m_data), 0);
        check("ar_step", 32'(m_step), 0);
        check("ar_start", 32'(start), 0);
        tick();
        rst = 1'b1;
        s0 = n_starts;
        d0 = n_dones;
        repeat (25) tick();
        check("ar_late_done_seen", 32'(n_dones - d0), 1);
        check("ar_late_ignored", 32'(count), 0);
        check("ar_no_start", 32'(n_starts - s0), 0);

`ifdef MULT_SEQ_ACCUM_EN
        // 257 products of 0xFFFF wrap a 24-bit sum
        do_reset();
        mdl_data = 16'hFFFF;
        mdl_step = 8'd1;
        mdl_lat  = 1;
        m_ready  = 1'b1;
        s0       = n_starts;
        d0       = n_dones;
        run      = 1'b1;
        k        = 0;
        while ((n_starts - s0) < 257 && k < 2000) begin
            tick();
            k++;
        end
        run = 1'b0;
        k   = 0;
        while ((n_dones - d0) < 257 && k < 20) begin
            tick();
            k++;
        end
        tick();
        exp_sum = 64'd257 * 64'd65535;
        check("acc_starts", 32'(n_starts - s0), 257);
        check("acc_value", 32'(acc), 32'(exp_sum & 64'hFF_FFFF));
        check("acc_ovf", 32'(acc_ovf), (exp_sum >= 64'h100_0000) ? 32'd1 : 32'd0);
        m_ready = 1'b0;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_clr_value", 32'(acc), 0);
        check("acc_clr_ovf", 32'(acc_ovf), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
